// File: rtl/thermo_pkg.sv
// ============================================================================
//  Module   : thermo_pkg
//  Brief    : Shared widths, direction codes and FSM states for thermo_decoder.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package thermo_pkg;

    localparam int THERMO_W = 15;
    localparam int CNT_W    = 4;
    localparam int RUN_W    = 3;

    typedef enum logic [1:0] {
        DIR_HOLD = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10,
        DIR_JUMP = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'b00,
        ST_SETTLING = 2'b01,
        ST_LOCKED   = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/thermo_decoder_check.sv
// ============================================================================
//  Module   : thermo_check
//  Brief    : Validates a thermometer code and returns its population count.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module thermo_check
    import thermo_pkg::*;
(
    input  logic [THERMO_W-1:0] code,
    output logic                is_valid,
    output logic [CNT_W-1:0]    value
);

    logic [THERMO_W-1:0] w_code_inc;

    // A legal code is a contiguous run of ones from bit 0, so code+1 shares no set bit with it.
    assign w_code_inc = code + THERMO_W'(1);
    assign is_valid   = ((code & w_code_inc) == '0);

    always_comb begin
        value = '0;
        for (int i = 0; i < THERMO_W; i++) begin
            value = value + CNT_W'(code[i]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/thermo_decoder.sv
// ============================================================================
//  Module   : thermo_decoder
//  Brief    : Debounced thermometer-code decoder with direction/wrap/error flags.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module thermo_decoder
    import thermo_pkg::*;
#(
    parameter int STABLE_CNT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_en,
    input  logic [THERMO_W-1:0] thermo_in,
    input  logic                err_clr,
    output logic [CNT_W-1:0]    count,
    output logic                valid,
    output logic                upd,
    output logic [1:0]          dir,
    output logic                wrap,
    output logic                err
);

    localparam logic [RUN_W-1:0] c_stable = RUN_W'(STABLE_CNT);

    logic                w_is_valid;
    logic [CNT_W-1:0]    w_value;
    logic [CNT_W-1:0]    w_count_inc;
    logic [CNT_W-1:0]    w_count_dec;

    state_t              r_state,  w_state_nx;
    logic [CNT_W-1:0]    r_cand,   w_cand_nx;
    logic [RUN_W-1:0]    r_run,    w_run_nx;
    logic [CNT_W-1:0]    r_count,  w_count_nx;
    logic                r_valid,  w_valid_nx;
    logic                r_upd,    w_upd_nx;
    dir_t                r_dir,    w_dir_nx;
    logic                r_wrap,   w_wrap_nx;
    logic                r_err,    w_err_nx;

    thermo_check u_check (
        .code     (thermo_in),
        .is_valid (w_is_valid),
        .value    (w_value)
    );

    assign w_count_inc = r_count + CNT_W'(1);
    assign w_count_dec = r_count - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_cand  <= '0;
            r_run   <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_upd   <= 1'b0;
            r_dir   <= DIR_HOLD;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cand  <= w_cand_nx;
            r_run   <= w_run_nx;
            r_count <= w_count_nx;
            r_valid <= w_valid_nx;
            r_upd   <= w_upd_nx;
            r_dir   <= w_dir_nx;
            r_wrap  <= w_wrap_nx;
            r_err   <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cand_nx  = r_cand;
        w_run_nx   = r_run;
        w_count_nx = r_count;
        w_valid_nx = r_valid;
        w_upd_nx   = 1'b0;
        w_dir_nx   = r_dir;
        w_wrap_nx  = 1'b0;
        w_err_nx   = r_err;

        // Clear first so a simultaneous bubble re-sets the flag.
        if (err_clr) begin
            w_err_nx = 1'b0;
        end

        if (sample_en) begin
            if (!w_is_valid) begin
                w_err_nx   = 1'b1;
                w_run_nx   = '0;
                w_state_nx = ST_SETTLING;
            end else begin
                if ((w_value == r_cand) && (r_run != '0)) begin
                    if (r_run < c_stable) begin
                        w_run_nx = r_run + RUN_W'(1);
                    end
                end else begin
                    w_cand_nx = w_value;
                    w_run_nx  = RUN_W'(1);
                end

                if ((w_run_nx == c_stable) && ((w_cand_nx != r_count) || !r_valid)) begin
                    w_count_nx = w_cand_nx;
                    w_valid_nx = 1'b1;
                    w_upd_nx   = 1'b1;
                    w_state_nx = ST_LOCKED;
                    if (!r_valid) begin
                        w_dir_nx = DIR_HOLD;
                    end else if (w_cand_nx == w_count_inc) begin
                        w_dir_nx  = DIR_UP;
                        w_wrap_nx = (w_cand_nx == '0);
                    end else if (w_cand_nx == w_count_dec) begin
                        w_dir_nx  = DIR_DOWN;
                        w_wrap_nx = (w_cand_nx == '1);
                    end else begin
                        w_dir_nx = DIR_JUMP;
                    end
                end else if (r_valid && (w_cand_nx == r_count)) begin
                    w_state_nx = ST_LOCKED;
                end else begin
                    w_state_nx = ST_SETTLING;
                end
            end
        end
    end

    assign count = r_count;
    assign valid = r_valid;
    assign upd   = r_upd;
    assign dir   = r_dir;
    assign wrap  = r_wrap;
    assign err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_thermo_decoder.sv
// ============================================================================
//  Module   : tb_thermo_decoder
//  Brief    : Directed self-checking bench with a history-based reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_thermo_decoder;
    import thermo_pkg::*;

    localparam int STABLE_CNT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_en = 1'b0;
    logic [14:0] thermo_in = '0;
    logic        err_clr = 1'b0;
    logic [3:0]  count;
    logic        valid;
    logic        upd;
    logic [1:0]  dir;
    logic        wrap;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    thermo_decoder #(.STABLE_CNT(STABLE_CNT)) dut (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample_en),
        .thermo_in (thermo_in),
        .err_clr   (err_clr),
        .count     (count),
        .valid     (valid),
        .upd       (upd),
        .dir       (dir),
        .wrap      (wrap),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference model: remembers the valid values seen since the last bubble/reset.
    int   hist[$];
    int   m_count, m_dir;
    bit   m_valid, m_upd, m_wrap, m_err;
    bit   model_ready = 0;

    always @(posedge clk) begin
        int  v;
        bit  ok;
        bit  stable;
        int  diff;
        ok = 0;
        v  = 0;
        for (int k = 0; k <= 15; k++) begin
            if (int'(thermo_in) == (1 << k) - 1) begin
                ok = 1;
                v  = k;
            end
        end
        if (reset) begin
            hist.delete();
            m_count = 0; m_dir = 0; m_valid = 0; m_upd = 0; m_wrap = 0; m_err = 0;
        end else begin
            m_upd  = 0;
            m_wrap = 0;
            if (err_clr) m_err = 0;
            if (sample_en) begin
                if (!ok) begin
                    m_err = 1;
                    hist.delete();
                end else begin
                    hist.push_back(v);
                    if (hist.size() > 8) void'(hist.pop_front());
                    stable = (hist.size() >= STABLE_CNT);
                    for (int j = 0; j < STABLE_CNT && stable; j++)
                        if (hist[hist.size() - 1 - j] != v) stable = 0;
                    if (stable && (v != m_count || !m_valid)) begin
                        diff = (v - m_count + 16) % 16;
                        if (!m_valid)       m_dir = 0;
                        else if (diff == 1) begin m_dir = 1; m_wrap = (m_count == 15); end
                        else if (diff == 15) begin m_dir = 2; m_wrap = (m_count == 0); end
                        else                m_dir = 3;
                        m_count = v;
                        m_valid = 1;
                        m_upd   = 1;
                    end
                end
            end
        end
        model_ready = 1;
    end

    always @(negedge clk) begin
        if (model_ready) begin
            n_tests++;
            if (count !== 4'(m_count) || valid !== m_valid || upd !== m_upd ||
                dir !== 2'(m_dir) || wrap !== m_wrap || err !== m_err) begin
                n_fail++;
                $display("FAIL model t=%0t got cnt=%0d v=%0b u=%0b d=%0d w=%0b e=%0b exp cnt=%0d v=%0b u=%0b d=%0d w=%0b e=%0b",
                         $time, count, valid, upd, dir, wrap, err,
                         m_count, m_valid, m_upd, m_dir, m_wrap, m_err);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [14:0] code, input int n);
        repeat (n) begin
            @(negedge clk);
            sample_en = 1'b1;
            thermo_in = code;
        end
        @(negedge clk);
        sample_en = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_dir",   32'(dir),   0);
        check("rst_err",   32'(err),   0);

        strobe(15'h0007, 1);
        check("first_no_upd", 32'(upd), 0);
        check("first_valid0", 32'(valid), 0);
        strobe(15'h0007, 1);
        check("c3_upd",   32'(upd),   1);
        check("c3_count", 32'(count), 3);
        check("c3_dir",   32'(dir),   0);

        strobe(15'h000F, 2);
        check("up_count", 32'(count), 4);
        check("up_dir",   32'(dir),   1);
        check("up_wrap",  32'(wrap),  0);
        strobe(15'h0007, 2);
        check("dn_count", 32'(count), 3);
        check("dn_dir",   32'(dir),   2);

        strobe(15'h7FFF, 2);
        check("j15_dir", 32'(dir), 3);
        strobe(15'h0000, 2);
        check("wrapup_count", 32'(count), 0);
        check("wrapup_dir",   32'(dir),   1);
        check("wrapup_wrap",  32'(wrap),  1);
        @(negedge clk);
        check("wrap_pulse_end", 32'(wrap), 0);
        strobe(15'h7FFF, 2);
        check("wrapdn_dir",  32'(dir),  2);
        check("wrapdn_wrap", 32'(wrap), 1);

        strobe(15'h7FFF, 6);
        check("held_no_upd", 32'(upd), 0);

        strobe(15'h0005, 1);
        check("bubble_err",   32'(err),   1);
        check("bubble_count", 32'(count), 15);
        @(negedge clk);
        err_clr = 1'b1; sample_en = 1'b1; thermo_in = 15'h0009;
        @(negedge clk);
        err_clr = 1'b0; sample_en = 1'b0;
        check("set_wins", 32'(err), 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_clr", 32'(err), 0);

        strobe(15'h003F, 1);
        check("single_no_upd", 32'(upd),   0);
        check("single_count",  32'(count), 15);
        strobe(15'h00FF, 2);
        check("jump_count", 32'(count), 8);
        check("jump_dir",   32'(dir),   3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            thermo_in = 15'(1 << i);
        end
        @(negedge clk);
        check("en_low_count", 32'(count), 8);

        strobe(15'h001F, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_err",   32'(err),   0);
        check("mid_rst_state", 32'(dut.r_state), 32'(ST_EMPTY));
        strobe(15'h0003, 2);
        check("post_rst_count", 32'(count), 2);
        check("post_rst_dir",   32'(dir),   0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/thermo_decoder.md
THERMO_DECODER -- requirements
Module: thermo_decoder

Interface
REQ-001 The parameter STABLE_CNT SHALL default to 2 and SHALL set the number of consecutive identical valid samples required before a commit (legal range 1..7).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 sample_en  input  1  SHALL be the sample strobe (divided-clock tick); thermo_in SHALL be ignored while it is low.
REQ-005 thermo_in  input  15  SHALL carry the thermometer code; bit k=1 means the count is greater than k.
REQ-006 err_clr  input  1  SHALL clear the sticky error flag.
REQ-007 count  output  4  SHALL carry the last committed decoded value.
REQ-008 valid  output  1  SHALL be high once at least one value has been committed since reset.
REQ-009 upd  output  1  SHALL pulse high for one cycle on each commit.
REQ-010 dir  output  2  SHALL encode the last transition: 00 hold/first, 01 up, 10 down, 11 jump.
REQ-011 wrap  output  1  SHALL pulse high for one cycle on a 15->0 or 0->15 commit.
REQ-012 err  output  1  SHALL be a sticky flag indicating a non-thermometer sample was seen.

Function
REQ-013 A sample SHALL be valid iff thermo_in == 2^k-1 for some k in 0..15; its decoded value SHALL be k.
REQ-014 An invalid sample (bubble) on sample_en SHALL set err, discard the sample, and return the FSM to SETTLING with the run counter at 0; count, valid and dir SHALL hold.
REQ-015 The FSM SHALL have three states: EMPTY (after reset, valid=0), SETTLING (candidate run in progress) and LOCKED (candidate equals count).
REQ-016 For a valid sample with value equal to the candidate, the 3-bit run counter SHALL increment and saturate at STABLE_CNT; for a valid sample with a different value, the candidate SHALL be loaded and the run SHALL be set to 1.
REQ-017 Commit SHALL occur when the run reaches STABLE_CNT and the candidate differs from count or valid=0: count<=candidate, valid<=1, upd=1, and the state SHALL move to LOCKED.
REQ-018 Commit latency SHALL be as follows: outputs SHALL change on the clock edge that samples the qualifying sample_en, i.e. registered, with no further delay; with STABLE_CNT=1 every valid changed sample SHALL commit immediately.
REQ-019 In LOCKED, a valid sample equal to count SHALL produce no upd; a different value SHALL move the FSM to SETTLING.
REQ-020 dir on commit SHALL be computed as follows: 00 if this is the first commit after reset; 01 if new == old+1 mod 16; 10 if new == old-1 mod 16; 11 otherwise. dir SHALL hold between commits.
REQ-021 wrap SHALL pulse together with upd only for old=15,new=0 (dir=01) or old=0,new=15 (dir=10).
REQ-022 If err_clr is high in the same cycle as a bubble sample, err SHALL remain 1 (set wins).
REQ-023 upd and wrap SHALL be single-cycle pulses even if sample_en is held high continuously.

Reset
REQ-024 Reset SHALL force count=0, valid=0, upd=0, dir=00, wrap=0 and err=0, clear the candidate and run counter, and set the state to EMPTY; it SHALL override all other inputs, including mid-settle.
REQ-025 The first commit after reset SHALL report dir=00 and wrap=0 regardless of its value.

Structure
REQ-026 Package thermo_pkg SHALL hold THERMO_W=15, CNT_W=4, the dir encodings (DIR_HOLD, DIR_UP, DIR_DOWN, DIR_JUMP) and the FSM state encodings.
REQ-027 Combinational sub-module thermo_check SHALL take a 15-bit code and output is_valid plus a 4-bit value; thermo_decoder SHALL instantiate it once.

Verification
REQ-028 Reset, then sample 0x0007 twice (STABLE_CNT=2) -> upd once after the second strobe; count=3, valid=1, dir=00.
REQ-029 Count 3 then sample 0x000F x2 -> count=4, dir=01, wrap=0; then 0x0007 x2 -> count=3, dir=10.
REQ-030 Count 15 (0x7FFF) then 0x0000 x2 -> count=0, dir=01, wrap=1 for one cycle; then 0x7FFF x2 -> dir=10, wrap=1.
REQ-031 Sample 0x0005 -> err=1, count unchanged; err_clr together with 0x0009 -> err stays 1; err_clr alone -> err=0.
REQ-032 Sample 0x003F once, then 0x00FF x2 -> no commit at 0x003F, commit count=8, dir=11; with sample_en low, changing thermo_in -> no change.
REQ-033 Assert reset after one 0x001F sample (mid-settle) -> all outputs 0 and the FSM in EMPTY; the next commit reports dir=00.
